// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request sequencer and the GCD core:
// bus width, default timeout and the sequencer state encoding.
package gcd_pkg;

   localparam int GCD_WIDTH          = 16;
   localparam int GCD_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_LOAD_B = 3'd3,
      ST_WAIT   = 3'd4,
      ST_RESP   = 3'd5
   } gcd_state_t;

   // Width of the WAIT-cycle counter; never below one bit.
   function automatic int timeout_cnt_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/gcd_request_sequencer_if.sv
// Request/response channels plus the core start/data/done bus.
// slave: the sequencer. master: the requester and core side.
interface gcd_request_sequencer_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_gcd;
   logic             rsp_timeout;
   logic             core_start;
   logic [WIDTH-1:0] core_data;
   logic             core_done;
   logic [WIDTH-1:0] core_result;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, core_done, core_result,
      output req_ready, rsp_valid, rsp_gcd, rsp_timeout, core_start, core_data
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, core_done, core_result,
      input  req_ready, rsp_valid, rsp_gcd, rsp_timeout, core_start, core_data
   );
endinterface

// File: rtl/gcd_timeout_counter.sv
// Counts cycles spent waiting on the core and flags the last allowed cycle.
module gcd_timeout_counter
   import gcd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int            CW   = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Clear outside WAIT, advance one step per WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LAST);
endmodule

// File: rtl/gcd_request_sequencer.sv
// Initiator front end for the subtractive GCD core: accepts operand pairs,
// drives start plus the A/B bus loads, waits for done (with timeout) and
// returns the result. Zero operands bypass the core entirely.
module gcd_request_sequencer
   import gcd_pkg::*;
#(
   parameter int WIDTH          = GCD_WIDTH,
   parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
   input logic                  clk,
   input logic                  rst_n,
   gcd_request_sequencer_if.slave bus
);
   gcd_state_t       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] rsp_gcd_reg;
   logic [WIDTH-1:0] core_data_reg;
   logic             req_ready_reg;
   logic             rsp_valid_reg;
   logic             rsp_timeout_reg;
   logic             core_start_reg;
   logic             cnt_enable;
   logic             cnt_clear;
   logic             cnt_expired;

   assign cnt_enable = (state == ST_WAIT);
   assign cnt_clear  = !cnt_enable;

   gcd_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .expired (cnt_expired)
   );

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         a_reg           <= '0;
         b_reg           <= '0;
         rsp_gcd_reg     <= '0;
         core_data_reg   <= '0;
         req_ready_reg   <= 1'b1;
         rsp_valid_reg   <= 1'b0;
         rsp_timeout_reg <= 1'b0;
         core_start_reg  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && req_ready_reg) begin
                  a_reg         <= bus.req_a;
                  b_reg         <= bus.req_b;
                  req_ready_reg <= 1'b0;
                  if ((bus.req_a == '0) || (bus.req_b == '0)) begin
                     // The core never terminates on a zero operand; answer directly.
                     rsp_gcd_reg     <= bus.req_a | bus.req_b;
                     rsp_timeout_reg <= 1'b0;
                     rsp_valid_reg   <= 1'b1;
                     state           <= ST_RESP;
                  end else begin
                     core_start_reg <= 1'b1;
                     core_data_reg  <= '0;
                     state          <= ST_START;
                  end
               end
            end
            ST_START: begin
               core_start_reg <= 1'b0;
               core_data_reg  <= a_reg;
               state          <= ST_LOAD_A;
            end
            ST_LOAD_A: begin
               core_data_reg <= b_reg;
               state         <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               core_data_reg <= '0;
               state         <= ST_WAIT;
            end
            ST_WAIT: begin
               // Done takes priority over an expiring timeout.
               if (bus.core_done) begin
                  rsp_gcd_reg     <= bus.core_result;
                  rsp_timeout_reg <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  state           <= ST_RESP;
               end else if (cnt_expired) begin
                  rsp_gcd_reg     <= '0;
                  rsp_timeout_reg <= 1'b1;
                  rsp_valid_reg   <= 1'b1;
                  state           <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               core_start_reg <= 1'b0;
               core_data_reg  <= '0;
               rsp_valid_reg  <= 1'b0;
               req_ready_reg  <= 1'b1;
               state          <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_reg;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_gcd     = rsp_gcd_reg;
   assign bus.rsp_timeout = rsp_timeout_reg;
   assign bus.core_start  = core_start_reg;
   assign bus.core_data   = core_data_reg;
endmodule
